// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: N_CH-to-1 AXI-Stream packet arbiter.
// A round-robin pointer picks the next requesting channel while IDLE. That
// channel then owns the master port until its tlast beat is accepted. Beats
// pass through a 2-entry skid buffer that carries data, last, one-hot grant
// and (optionally) the source index together.
// Optional feature: define AXIS_ARB_TID_EN to add m_axis_tid, the binary
// source index of the presented beat.
//
// Handshake rule for every stream port: a beat transfers on a rising edge
// where valid and ready are both 1. Once valid is raised, it and its payload
// hold until that transfer happens. Ready may be 0 or 1 at any time.
module axis_rr_arbiter #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 32,
   localparam int IDX_W = $clog2(N_CH)
) (
   input  logic                   axis_aclk,
   input  logic                   axis_areset,
   input  logic [N_CH*DATA_W-1:0] s_axis_tdata,
   input  logic [N_CH-1:0]        s_axis_tvalid,
   output logic [N_CH-1:0]        s_axis_tready,
   input  logic [N_CH-1:0]        s_axis_tlast,
   output logic [DATA_W-1:0]      m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic [N_CH-1:0]        m_axis_grant,
`ifdef AXIS_ARB_TID_EN
   output logic [IDX_W-1:0]       m_axis_tid,
`endif
   output logic                   o_dbg_state
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PASS = 1'b1
   } state_t;

   state_t            r_state;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [IDX_W-1:0]  r_gnt_idx;

   // Skid buffer: the head entry drives the master port directly, and
   // entry 1 holds a second beat while the master is stalled.
   logic [1:0]        r_cnt;
   logic [DATA_W-1:0] r_h_data;
   logic              r_h_last;
   logic [N_CH-1:0]   r_h_grant;
   logic [DATA_W-1:0] r_e1_data;
   logic              r_e1_last;
   logic [N_CH-1:0]   r_e1_grant;
`ifdef AXIS_ARB_TID_EN
   logic [IDX_W-1:0]  r_h_idx;
   logic [IDX_W-1:0]  r_e1_idx;
`endif

   logic              w_sel_found;
   logic [IDX_W-1:0]  w_sel_idx;
   logic [IDX_W-1:0]  w_ptr_next;
   logic [N_CH-1:0]   w_gnt_oh;
   logic [DATA_W-1:0] w_in_data;
   logic              w_in_last;
   logic              w_in_valid;
   logic              w_pass;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_head_load_in;
   logic              w_head_load_e1;

   // Search for the first requester at or after rr_ptr, wrapping at N_CH-1.
   always_comb begin
      int v_cand;
      v_cand      = 0;
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      for (int k = 0; k < N_CH; k++) begin
         v_cand = (int'(r_rr_ptr) + k) % N_CH;
         if (!w_sel_found && s_axis_tvalid[v_cand]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = IDX_W'(v_cand);
         end
      end
   end

   assign w_ptr_next = (r_gnt_idx == IDX_W'(N_CH - 1)) ? '0 : r_gnt_idx + 1'b1;
   assign w_gnt_oh   = {{(N_CH-1){1'b0}}, 1'b1} << r_gnt_idx;
   assign w_in_data  = s_axis_tdata[int'(r_gnt_idx)*DATA_W +: DATA_W];
   assign w_in_last  = s_axis_tlast[r_gnt_idx];
   assign w_in_valid = s_axis_tvalid[r_gnt_idx];

   assign w_pass = (r_state == ST_PASS);
   assign w_full = (r_cnt == 2'd2);
   assign w_push = w_pass && !w_full && w_in_valid;
   assign w_pop  = (r_cnt != 2'd0) && m_axis_tready;

   // The head takes the incoming beat when it would otherwise be empty next
   // cycle. It takes entry 1 when the buffer is full and the head drains.
   assign w_head_load_in = w_push && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));
   assign w_head_load_e1 = w_pop && (r_cnt == 2'd2);

   assign s_axis_tready = (w_pass && !w_full) ? w_gnt_oh : '0;
   assign m_axis_tvalid = (r_cnt != 2'd0);
   assign m_axis_tdata  = r_h_data;
   assign m_axis_tlast  = r_h_last;
   assign m_axis_grant  = r_h_grant;
`ifdef AXIS_ARB_TID_EN
   assign m_axis_tid    = r_h_idx;
`endif
   assign o_dbg_state   = r_state;

   // Arbiter FSM: grant in IDLE, hold the grant through PASS until tlast.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         r_state   <= ST_IDLE;
         r_rr_ptr  <= '0;
         r_gnt_idx <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_sel_found) begin
                  r_gnt_idx <= w_sel_idx;
                  r_state   <= ST_PASS;
               end
            end
            ST_PASS: begin
               if (w_push && w_in_last) begin
                  r_rr_ptr <= w_ptr_next;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Skid buffer: occupancy count plus head and entry-1 payload registers.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         r_cnt      <= 2'd0;
         r_h_data   <= '0;
         r_h_last   <= 1'b0;
         r_h_grant  <= '0;
         r_e1_data  <= '0;
         r_e1_last  <= 1'b0;
         r_e1_grant <= '0;
`ifdef AXIS_ARB_TID_EN
         r_h_idx    <= '0;
         r_e1_idx   <= '0;
`endif
      end else begin
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
         if (w_head_load_in) begin
            r_h_data  <= w_in_data;
            r_h_last  <= w_in_last;
            r_h_grant <= w_gnt_oh;
`ifdef AXIS_ARB_TID_EN
            r_h_idx   <= r_gnt_idx;
`endif
         end else if (w_head_load_e1) begin
            r_h_data  <= r_e1_data;
            r_h_last  <= r_e1_last;
            r_h_grant <= r_e1_grant;
`ifdef AXIS_ARB_TID_EN
            r_h_idx   <= r_e1_idx;
`endif
         end
         if (w_push && (r_cnt == 2'd1) && !w_pop) begin
            r_e1_data  <= w_in_data;
            r_e1_last  <= w_in_last;
            r_e1_grant <= w_gnt_oh;
`ifdef AXIS_ARB_TID_EN
            r_e1_idx   <= r_gnt_idx;
`endif
         end
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: bench for axis_rr_arbiter with N_CH=4 and DATA_W=32.
// The master stream is checked against an expected queue built from the
// packet order that round-robin arbitration must produce.
module tb_axis_rr_arbiter;
   localparam int N     = 4;
   localparam int W     = 32;
   localparam int IDX_W = 2;
   localparam int EXP_W = N + 1 + W;
   localparam int DEPTH = 1024;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic [N*W-1:0]   s_tdata;
   logic [N-1:0]     s_tvalid;
   logic [N-1:0]     s_tready;
   logic [N-1:0]     s_tlast;
   logic [W-1:0]     m_tdata;
   logic             m_tvalid;
   logic             m_tready;
   logic             m_tlast;
   logic [N-1:0]     m_grant;
   logic             dbg_state;
`ifdef AXIS_ARB_TID_EN
   logic [IDX_W-1:0] m_tid;
`endif

   always #5 clk = ~clk;

   axis_rr_arbiter #(.N_CH(N), .DATA_W(W)) dut (
      .axis_aclk     (clk),
      .axis_areset   (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .m_axis_grant  (m_grant),
`ifdef AXIS_ARB_TID_EN
      .m_axis_tid    (m_tid),
`endif
      .o_dbg_state   (dbg_state)
   );

   // ---------------- bench state ----------------
   int               checks = 0;
   int               errors = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [W+1:0]     ch_mem [N][DEPTH];   // {first, last, data}
   int               ch_rd[N];
   int               ch_wr[N];
   int               acc_cnt[N];
   int               cyc = 0;
   int               rdy_mode = 0;         // 0: master always ready, 1: random 50%
   bit               gap_en = 1'b0;        // random tvalid gaps inside packets
   bit               acc_prev = 1'b0;
   bit               stall_prev = 1'b0;
   logic [EXP_W-1:0] stall_word;
   bit               lock_valid = 1'b0;
   int               lock_ch = 0;
   logic [N-1:0]     last_acc;
   int               first_acc = -1;
   int               last_acc_cyc = 0;
   int               serial = 0;

   typedef struct {
      logic [N-1:0] mask;
      int           exp_ch;
   } rr_vec_t;
   rr_vec_t rr_tbl[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [EXP_W-1:0] make_exp(input int c, input logic last, input logic [W-1:0] d);
      logic [N-1:0] oh;
      oh = '0;
      oh[c] = 1'b1;
      return {oh, last, d};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic load_pkt(input int c, input int len, input logic [W-1:0] base, input bit push_exp);
      for (int i = 0; i < len; i++) begin
         ch_mem[c][ch_wr[c]] = {(i == 0), (i == len - 1), base + W'(i)};
         ch_wr[c]++;
         if (push_exp) exp_q.push_back(make_exp(c, (i == len - 1), base + W'(i)));
      end
   endtask

   task automatic drive();
      for (int c = 0; c < N; c++) begin
         if (ch_rd[c] < ch_wr[c]) begin
            logic [W+1:0] b;
            b = ch_mem[c][ch_rd[c]];
            s_tdata[c*W +: W] = b[W-1:0];
            s_tlast[c] = b[W];
            if (!s_tvalid[c])
               s_tvalid[c] = b[W+1] || !gap_en || ($urandom_range(0, 3) != 0);
         end else begin
            s_tvalid[c] = 1'b0;
            s_tlast[c]  = 1'b0;
         end
      end
      m_tready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
   endtask

   function automatic bit pending();
      for (int c = 0; c < N; c++) if (ch_rd[c] < ch_wr[c]) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: monitor at the falling edge, update stimulus after the rising edge.
   task automatic cycle();
      logic [N-1:0]     acc;
      logic [EXP_W-1:0] got;
      logic [EXP_W-1:0] e;
      @(negedge clk);
      acc = s_tvalid & s_tready;
      got = {m_grant, m_tlast, m_tdata};
      if (acc_prev) check("accept_to_valid", m_tvalid, 1);
      if (stall_prev) begin
         check("stall_valid", m_tvalid, 1);
         check("stall_payload", got, stall_word);
      end
      if (lock_valid) check("grant_lock", s_tready & ~(N'(1) << lock_ch), 0);
      if (m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat: got %0h expected none", got);
         end else begin
            e = exp_q.pop_front();
            check("beat", got, e);
`ifdef AXIS_ARB_TID_EN
            begin
               int idx;
               idx = 0;
               for (int c = 0; c < N; c++) if (e[W+1+c]) idx = c;
               check("tid", m_tid, idx);
            end
`endif
         end
      end
      stall_prev = m_tvalid && !m_tready;
      stall_word = got;
      @(posedge clk);
      #1;
      cyc++;
      last_acc = acc;
      acc_prev = (acc != 0);
      for (int c = 0; c < N; c++) begin
         if (acc[c]) begin
            lock_valid = !ch_mem[c][ch_rd[c]][W];
            lock_ch    = c;
            ch_rd[c]++;
            acc_cnt[c]++;
            s_tvalid[c] = 1'b0;
            if (first_acc < 0) first_acc = cyc;
            last_acc_cyc = cyc;
         end
      end
      drive();
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || pending()) && n < budget) begin
         cycle();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout with %0d beats outstanding, expected 0", name, exp_q.size());
      end
      // a few idle cycles so the last beat leaves the skid buffer
      repeat (3) cycle();
   endtask

   task automatic wait_accept(output int ch);
      ch = -1;
      for (int i = 0; i < 50 && ch < 0; i++) begin
         cycle();
         for (int c = 0; c < N; c++) if (last_acc[c]) ch = c;
      end
      if (ch < 0) begin
         checks++;
         errors++;
         $display("FAIL wait_accept: no accept within 50 cycles, expected one");
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int got_ch;
      int rel;
      int base0;
      int total;
      // Starting from rr_ptr=1, each row is {requesting mask, channel that must win}.
      rr_tbl[0]  = '{4'b1111, 1};
      rr_tbl[1]  = '{4'b1111, 2};
      rr_tbl[2]  = '{4'b0001, 0};
      rr_tbl[3]  = '{4'b1001, 3};
      rr_tbl[4]  = '{4'b0110, 1};
      rr_tbl[5]  = '{4'b0011, 0};
      rr_tbl[6]  = '{4'b1100, 2};
      rr_tbl[7]  = '{4'b1000, 3};
      rr_tbl[8]  = '{4'b0100, 2};
      rr_tbl[9]  = '{4'b0111, 0};
      rr_tbl[10] = '{4'b1111, 1};
      rr_tbl[11] = '{4'b0101, 2};

      for (int c = 0; c < N; c++) begin
         ch_rd[c]   = 0;
         ch_wr[c]   = 0;
         acc_cnt[c] = 0;
      end
      rst = 1'b1;
      s_tdata  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      m_tready = 1'b1;
      last_acc = '0;
      stall_word = '0;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_grant", m_grant, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_state", dbg_state, 0);
      s_tvalid = '1;
      s_tlast  = '1;
      repeat (2) @(negedge clk);
      check("rst_s_tready_req", s_tready, 0);
      check("rst_m_tvalid_req", m_tvalid, 0);
      s_tvalid = '0;
      s_tlast  = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // all four channels start 3-beat packets together
      first_acc = -1;
      load_pkt(0, 3, 32'h0A00, 1);
      load_pkt(1, 3, 32'h0B00, 1);
      load_pkt(2, 3, 32'h0C00, 1);
      load_pkt(3, 3, 32'h0D00, 1);
      load_pkt(0, 3, 32'h0E00, 1);
      drive();
      drain("rr_all", 200);
      check("rr_span", last_acc_cyc - first_acc, 18);

      // ch0 sends 1..10
      load_pkt(0, 10, 32'd1, 1);
      drive();
      drain("ch0_ten", 200);

      // table of arbitration decisions, single-beat packets
      for (int r = 0; r < 12; r++) begin
         for (int c = 0; c < N; c++) begin
            if (rr_tbl[r].mask[c])
               load_pkt(c, 1, 32'h1000 * (r + 1) + c, c == rr_tbl[r].exp_ch);
         end
         drive();
         wait_accept(got_ch);
         check("rr_table_grant", got_ch, rr_tbl[r].exp_ch);
         for (int c = 0; c < N; c++) ch_rd[c] = ch_wr[c];
         s_tvalid = '0;
         drive();
         drain("rr_table", 50);
      end

      // ch1 raises tvalid mid ch0 packet and must wait for ch0's tlast
      rdy_mode = 1;
      gap_en   = 1'b1;
      load_pkt(0, 6, 32'h2000, 1);
      drive();
      wait_accept(got_ch);
      check("lock_first", got_ch, 0);
      load_pkt(1, 2, 32'h2100, 1);
      drive();
      drain("lock", 300);

      // random master stalls, about 1000 beats, every channel always pending
      total = 0;
      for (int p = 0; total < 1000; p++) begin
         int len;
         len = $urandom_range(1, 8);
         serial += 16;
         load_pkt((2 + p) % N, len, 32'h0100_0000 + W'(serial), 1);
         total += len;
      end
      drive();
      drain("random", 20000);
      rdy_mode = 0;
      gap_en   = 1'b0;

      // reset mid-packet on beat 5 of a 10-beat ch0 packet
      load_pkt(0, 1, 32'h3000, 1);
      drive();
      drain("pre_reset", 50);
      base0 = acc_cnt[0];
      load_pkt(0, 10, 32'h3100, 1);
      drive();
      for (int i = 0; i < 100 && acc_cnt[0] < base0 + 5; i++) cycle();
      check("reset_beats_before", acc_cnt[0] - base0, 5);
      rst = 1'b1;
      #1;
      check("midrst_m_tvalid", m_tvalid, 0);
      check("midrst_s_tready", s_tready, 0);
      check("midrst_m_grant", m_grant, 0);
      check("midrst_m_tdata", m_tdata, 0);
      check("midrst_state", dbg_state, 0);
      exp_q.delete();
      for (int c = 0; c < N; c++) ch_rd[c] = ch_wr[c];
      s_tvalid = '0;
      acc_prev = 1'b0;
      stall_prev = 1'b0;
      lock_valid = 1'b0;
      drive();
      repeat (2) cycle();
      rst = 1'b0;
      rel = cyc;
      first_acc = -1;
      load_pkt(0, 1, 32'h3200, 1);
      load_pkt(1, 1, 32'h3300, 1);
      drive();
      drain("post_reset", 50);
      check("restart_latency", first_acc - rel, 2);
      load_pkt(1, 1, 32'h3400, 1);
      drive();
      drain("ch1_alone", 50);

      // ch2 packet: grant 0100 (and tid 2 when enabled) on every beat
      load_pkt(2, 3, 32'h4000, 1);
      drive();
      drain("ch2_pkt", 50);

      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // absolute time limit
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of slave channels, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 32, tdata width per channel, legal range 8..512.
REQ-003 SHALL have port axis_aclk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port axis_areset, input, 1, reset, asynchronous assert, active-high.
REQ-005 SHALL have port s_axis_tdata, input, N_CH*DATA_W, channel i occupies bits [i*DATA_W +: DATA_W].
REQ-006 SHALL have ports s_axis_tvalid (input), s_axis_tready (output) and s_axis_tlast (input), each N_CH wide, one bit per channel.
REQ-007 SHALL have port m_axis_tdata, output, DATA_W, forwarded beat data.
REQ-008 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1), master handshake.
REQ-009 SHALL have port m_axis_grant, output, N_CH, one-hot source of the beat currently on the master port.

Function
REQ-010 SHALL use arbiter FSM states IDLE and PASS, plus a round-robin pointer rr_ptr of clog2(N_CH) bits.
REQ-011 In IDLE, with any s_axis_tvalid high, SHALL select the first requesting channel at or after rr_ptr (wrapping N_CH-1 -> 0), register it as grant g, and enter PASS next cycle.
REQ-012 In IDLE, SHALL drive s_axis_tready all-zero; one arbitration bubble per packet is allowed.
REQ-013 In PASS, SHALL drive s_axis_tready[g] = skid buffer not full; all other s_axis_tready bits SHALL be 0.
REQ-014 SHALL lock the grant for a whole packet; requests on other channels SHALL NOT preempt it.
REQ-015 On acceptance of a beat with s_axis_tlast[g]=1, SHALL set rr_ptr = (g+1) mod N_CH and return to IDLE.
REQ-016 SHALL forward beats through a 2-entry skid buffer: 1 cycle latency from slave accept to m_axis_tvalid; 1 beat/cycle sustained within a packet.
REQ-017 SHALL carry tdata, tlast and one-hot grant through the skid buffer together, so m_axis_grant always matches the presented beat.
REQ-018 Once asserted, m_axis_tvalid and the master payload SHALL hold stable until m_axis_tready=1.
REQ-019 SHALL not drop, duplicate or reorder beats under any m_axis_tready pattern.
REQ-020 Single-beat packets (tlast on first beat) SHALL be legal and SHALL advance rr_ptr identically.
REQ-021 A granted channel dropping tvalid mid-packet SHALL keep the grant until it delivers tlast.

Reset
REQ-022 While axis_areset=1, the block SHALL force FSM=IDLE, rr_ptr=0, skid buffer empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_grant=0 and s_axis_tready=0.
REQ-023 Reset asserted mid-packet SHALL discard buffered beats and the grant; after release, arbitration SHALL restart from channel 0.
REQ-024 SHALL begin arbitration on the first rising edge after axis_areset deasserts.

Configuration
REQ-025 With macro AXIS_ARB_TID_EN defined, SHALL add output m_axis_tid, width clog2(N_CH), the binary index of the presented beat's source, carried in the skid buffer and reset to 0.
REQ-026 Without AXIS_ARB_TID_EN, m_axis_tid SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-027 N_CH=2, DATA_W=32, m_axis_tready=1; ch0 sends packet 1..10 with tlast on beat 10 -> master emits 1..10 in order with grant=01, tlast only on beat 10, m_axis_tvalid one cycle after each accept.
REQ-028 N_CH=4; all channels present 3-beat packets simultaneously from reset -> packet order ch0,ch1,ch2,ch3,ch0; one idle cycle between packets; no interleaving.
REQ-029 N_CH=2; ch0 mid-packet while ch1 raises tvalid -> ch1 s_axis_tready stays 0 until ch0's tlast beat is accepted, then ch1 is granted.
REQ-030 Random m_axis_tready at 50% duty over 1000 beats from 4 channels -> scoreboard shows zero loss, duplication or reorder, and master payload stable while stalled.
REQ-031 Assert axis_areset on beat 5 of a 10-beat packet -> m_axis_tvalid=0 within the same cycle; after release a new ch1 request is granted before a ch0 request only if ch0 is not requesting.
REQ-032 Build with AXIS_ARB_TID_EN, N_CH=4; ch2 sends packet -> m_axis_tid=2 and m_axis_grant=0100 on every beat.
